serial_sub16: RTL and testbench

- Bit-serial two's-complement subtractor: computes diff = A - B - bin, LSB first, one bit per clock, through a single full adder.
- Inverse-direction companion to the 16-bit ripple-carry adder. Area-cheap alternative for datapath paths that tolerate WIDTH-cycle latency.
- Start/done handshake, so a controller or bench can drive back-to-back operations.

---
 rtl/arith_pkg.sv | 17 +
 rtl/full_adder.sv | 16 +
 rtl/serial_sub16.sv | 154 +++++++++++++++
 tb/tb_serial_sub16.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   WIDTH_DEF : default operand/result width
//   CNT_W_DEF : bit-counter width for the default operand width
//   state_e   : serial-unit FSM encoding (the spare code 2'd3 recovers to IDLE)
package arith_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared with the ripple-carry adder.
// Ports:
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial two's-complement subtractor: diff = A - B - bin, LSB first,
// one bit per clock through a single full adder (A + ~B + ~bin).
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous, active-high reset
//   start : request, sampled only while ready=1
//   A, B  : minuend / subtrahend, captured on accepted start
//   bin   : borrow-in, captured on accepted start
//   ready : 1 while idle and able to accept start
//   done  : one-cycle pulse when diff/bout hold a new result
//   diff  : (A - B - bin) mod 2^WIDTH, registered
//   bout  : borrow-out, 1 iff A < B + bin, registered
module serial_sub16
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  // Only WIDTH-1 result bits are kept; the final bit comes straight from the adder.
  logic [WIDTH-2:0] acc_r;
  logic [WIDTH-1:0] acc_next_s;
  logic             carry_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             last_bit_s;
  logic             ready_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  full_adder u_fa (
    .a    (a_r[0]),
    .b    (~b_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  assign acc_next_s = {fa_sum_s, acc_r};
  assign last_bit_s = (state_r == ST_RUN) && (cnt_r == LAST_CNT);

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE:    state_s = ST_IDLE;
      ST_ILLEGAL: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and per-bit shifting of operands, carry and partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= ~bin;
            cnt_r   <= '0;
            acc_r   <= '0;
          end
        end
        ST_RUN: begin
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          acc_r   <= acc_next_s[WIDTH-1:1];
          carry_r <= fa_cout_s;
          // Explicit wrap keeps non-power-of-two widths correct.
          if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; results change only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      diff_r  <= '0;
      bout_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      if (last_bit_s) begin
        diff_r <= acc_next_s;
        bout_r <= ~fa_cout_s;
      end
    end
  end

  assign ready = ready_r;
  assign done  = done_r;
  assign diff  = diff_r;
  assign bout  = bout_r;

endmodule

// File: tb/tb_serial_sub16.sv
module tb_serial_sub16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bin;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_sub16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  // Reference: plain signed arithmetic on the integer values.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int full;
    logic [W-1:0] d;
    logic bo;
    full = int'(a) - int'(b) - int'(bi);
    d = full[W-1:0];
    bo = (full < 0);
    return {bo, d};
  endfunction

  // Issue one operation at the first cycle ready=1 and watch it to completion.
  // lat = number of edges after the accepting edge until done is seen (-1 if never).
  // changes = cycles during the run in which diff/bout differed from their pre-start value.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output int lat, output int changes,
                       output logic [W-1:0] d, output logic bo);
    logic [W-1:0] d0;
    logic b0;
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    d0 = diff;
    b0 = bout;
    A = a; B = b; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); bin = 1'($urandom);
    lat = -1;
    changes = 0;
    for (int j = 0; j < 40; j++) begin
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      if (diff !== d0 || bout !== b0) changes++;
      @(negedge clk);
    end
    d = diff;
    bo = bout;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b done=%b diff=%0d bout=%b, required 1 0 0 0", ready, done, diff, bout);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b done=%b diff=%0d bout=%b, required 1 0 0 0", ready, done, diff, bout);
    end
  endtask

  task automatic test_latency();
    int lat, ch;
    logic [W-1:0] d;
    logic bo;
    logic [W:0] exp;
    exp = ref_sub(16'd65000, 16'd65340, 1'b0);
    do_op(16'd65000, 16'd65340, 1'b0, lat, ch, d, bo);
    n_cmp++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL latency: done after %0d edges, required %0d", lat, W);
    end
    n_cmp++;
    if (d !== exp[W-1:0] || bo !== exp[W] || d !== 16'd65196) begin
      n_fail++;
      $display("FAIL first_result: diff=%0d bout=%b, required %0d %b", d, bo, exp[W-1:0], exp[W]);
    end
    n_cmp++;
    if (ch != 0) begin
      n_fail++;
      $display("FAIL first_stable: %0d changes during run, required 0", ch);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_return: ready=%b done=%b, required 1 0", ready, done);
    end
  endtask

  task automatic test_sequence();
    logic [W-1:0] ta [3] = '{16'd61727, 16'd1075, 16'd20508};
    logic [W-1:0] tb [3] = '{16'd3592, 16'd69, 16'd5383};
    logic         tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] te [3] = '{16'd58135, 16'd1005, 16'd15124};
    int lat, ch;
    logic [W-1:0] d;
    logic bo;
    logic [W:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = ref_sub(ta[i], tb[i], tc[i]);
      do_op(ta[i], tb[i], tc[i], lat, ch, d, bo);
      n_cmp++;
      if (lat != W || ch != 0 || d !== exp[W-1:0] || bo !== exp[W] || d !== te[i]) begin
        n_fail++;
        $display("FAIL seq_%0d: lat=%0d changes=%0d diff=%0d bout=%b, required lat=%0d 0 %0d %b",
                 i, lat, ch, d, bo, W, exp[W-1:0], exp[W]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [3] = '{16'd0, 16'd0, 16'd12345};
    logic [W-1:0] tb [3] = '{16'd0, 16'd65535, 16'd12345};
    logic         tc [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] te [3] = '{16'd65535, 16'd0, 16'd0};
    logic         tbo [3] = '{1'b1, 1'b1, 1'b0};
    int lat, ch;
    logic [W-1:0] d;
    logic bo;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], tc[i], lat, ch, d, bo);
      n_cmp++;
      if (lat != W || d !== te[i] || bo !== tbo[i]) begin
        n_fail++;
        $display("FAIL boundary_%0d: lat=%0d diff=%0d bout=%b, required lat=%0d %0d %b",
                 i, lat, d, bo, W, te[i], tbo[i]);
      end
    end
  endtask

  task automatic test_busy();
    int ndone, first;
    logic [W-1:0] d;
    logic bo;
    while (ready !== 1'b1) @(negedge clk);
    A = 16'd100; B = 16'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first = -1; d = '0; bo = 1'b0;
    for (int j = 0; j < 45; j++) begin
      start = 1'b0;
      if (j == 3 || j == 16) begin
        A = 16'd5; B = 16'd9; start = 1'b1;
      end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = j; d = diff; bo = bout;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 1 || first != W) begin
      n_fail++;
      $display("FAIL busy_done_count: %0d dones first at %0d, required 1 at %0d", ndone, first, W);
    end
    n_cmp++;
    if (d !== 16'd99 || bo !== 1'b0 || diff !== 16'd99) begin
      n_fail++;
      $display("FAIL busy_result: diff=%0d bout=%b, required 99 0", d, bo);
    end
  endtask

  task automatic test_abort();
    int ndone, lat, ch;
    logic [W-1:0] d;
    logic bo;
    while (ready !== 1'b1) @(negedge clk);
    A = 16'd500; B = 16'd20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: ready=%b done=%b diff=%0d bout=%b, required 1 0 0 0", ready, done, diff, bout);
    end
    for (int j = 0; j < 20; j++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d dones, required 0", ndone);
    end
    do_op(16'd500, 16'd20, 1'b0, lat, ch, d, bo);
    n_cmp++;
    if (lat != W || d !== 16'd480 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_fresh: lat=%0d diff=%0d bout=%b, required %0d 480 0", lat, d, bo, W);
    end
  endtask

  task automatic test_reset_priority();
    int ndone, nbusy;
    while (ready !== 1'b1) @(negedge clk);
    A = 16'd7; B = 16'd3; bin = 1'b0; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    ndone = 0; nbusy = 0;
    for (int j = 0; j < 20; j++) begin
      if (done === 1'b1) ndone++;
      if (ready !== 1'b1) nbusy++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone != 0 || nbusy != 0 || diff !== '0) begin
      n_fail++;
      $display("FAIL reset_priority: dones=%0d busy_cycles=%0d diff=%0d, required 0 0 0", ndone, nbusy, diff);
    end
  endtask

  task automatic test_random();
    int lat, ch;
    logic [W-1:0] a, b, d;
    logic bi, bo;
    logic [W:0] exp;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = (i % 5 == 0) ? a : W'($urandom);
      bi = 1'($urandom);
      exp = ref_sub(a, b, bi);
      do_op(a, b, bi, lat, ch, d, bo);
      n_cmp++;
      if (lat != W || ch != 0 || d !== exp[W-1:0] || bo !== exp[W]) begin
        n_fail++;
        $display("FAIL random_%0d: A=%0d B=%0d bin=%b lat=%0d changes=%0d diff=%0d bout=%b, required lat=%0d 0 %0d %b",
                 i, a, b, bi, lat, ch, d, bo, W, exp[W-1:0], exp[W]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sequence();
    test_boundaries();
    test_busy();
    test_abort();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
